// File: rtl/shift_reg_595_if.sv
// rtl/shift_reg_595_if.sv - pin bundle of the 74HC595 model, grouped by direction
interface shift_reg_595_if;
    logic pin14;
    logic pin11;
    logic pin12;
    logic pin10;
    logic pin13;
    logic pin8;
    logic pin16;
    wire  pin15;
    wire  pin1;
    wire  pin2;
    wire  pin3;
    wire  pin4;
    wire  pin5;
    wire  pin6;
    wire  pin7;
    logic pin9;

    // board side drives the control pins and reads the parallel/serial outputs
    modport master (
        output pin14, pin11, pin12, pin10, pin13, pin8, pin16,
        input  pin15, pin1, pin2, pin3, pin4, pin5, pin6, pin7, pin9
    );

    modport slave (
        input  pin14, pin11, pin12, pin10, pin13, pin8, pin16,
        output pin15, pin1, pin2, pin3, pin4, pin5, pin6, pin7, pin9
    );
endinterface

// File: rtl/shift_reg_595.sv
// rtl/shift_reg_595.sv - cycle-based 74HC595: sampled SRCLK/RCLK, shift + storage registers, tri-state outputs
// Optional macro SHIFT595_INPUT_SYNC_EN adds a two-flop synchronizer ahead of the sample stage.
module shift_reg_595 #(
    parameter logic [7:0] RST_Q = 8'h00
) (
    input  logic            clk,
    input  logic            rst,
    shift_reg_595_if.slave  bus
);

    logic in_ser;
    logic in_srclk;
    logic in_rclk;
    logic in_clr;

`ifdef SHIFT595_INPUT_SYNC_EN
    // bit order {clr, rclk, srclk, ser}; equal depth keeps SER aligned with SRCLK
    localparam logic [3:0] SYNC_RST = 4'b1110;

    logic [3:0] sync1_q;
    logic [3:0] sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= SYNC_RST;
            sync2_q <= SYNC_RST;
        end else begin
            sync1_q <= {bus.pin10, bus.pin12, bus.pin11, bus.pin14};
            sync2_q <= sync1_q;
        end
    end

    assign in_ser   = sync2_q[0];
    assign in_srclk = sync2_q[1];
    assign in_rclk  = sync2_q[2];
    assign in_clr   = sync2_q[3];
`else
    assign in_ser   = bus.pin14;
    assign in_srclk = bus.pin11;
    assign in_rclk  = bus.pin12;
    assign in_clr   = bus.pin10;
`endif

    logic s_ser_q;
    logic s_srclk_q;
    logic s_rclk_q;
    logic s_clr_q;
    logic p_srclk_q;
    logic p_rclk_q;

    logic [7:0] sr_q;
    logic [7:0] sr_d;
    logic [7:0] st_q;
    logic [7:0] st_d;

    logic sh_edge;
    logic lt_edge;

    // clock-like pins reset high so a pin held high through reset release is not an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            s_ser_q   <= 1'b0;
            s_srclk_q <= 1'b1;
            s_rclk_q  <= 1'b1;
            s_clr_q   <= 1'b1;
            p_srclk_q <= 1'b1;
            p_rclk_q  <= 1'b1;
        end else begin
            s_ser_q   <= in_ser;
            s_srclk_q <= in_srclk;
            s_rclk_q  <= in_rclk;
            s_clr_q   <= in_clr;
            p_srclk_q <= s_srclk_q;
            p_rclk_q  <= s_rclk_q;
        end
    end

    assign sh_edge = s_srclk_q & ~p_srclk_q;
    assign lt_edge = s_rclk_q & ~p_rclk_q;

    always_comb begin
        sr_d = sr_q;
        st_d = st_q;
        if (!s_clr_q) begin
            sr_d = 8'h00;
        end else if (sh_edge) begin
            sr_d = {sr_q[6:0], s_ser_q};
        end
        // storage captures the pre-shift value, so tied clocks leave it one bit behind
        if (lt_edge) begin
            st_d = sr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= RST_Q;
            st_q <= RST_Q;
        end else begin
            sr_q <= sr_d;
            st_q <= st_d;
        end
    end

    assign bus.pin15 = bus.pin13 ? 1'bz : st_q[0];
    assign bus.pin1  = bus.pin13 ? 1'bz : st_q[1];
    assign bus.pin2  = bus.pin13 ? 1'bz : st_q[2];
    assign bus.pin3  = bus.pin13 ? 1'bz : st_q[3];
    assign bus.pin4  = bus.pin13 ? 1'bz : st_q[4];
    assign bus.pin5  = bus.pin13 ? 1'bz : st_q[5];
    assign bus.pin6  = bus.pin13 ? 1'bz : st_q[6];
    assign bus.pin7  = bus.pin13 ? 1'bz : st_q[7];
    assign bus.pin9  = sr_q[7];

    // power pins exist only for pin compatibility
    wire unused_pwr = &{1'b0, bus.pin8, bus.pin16};

endmodule

// File: tb/tb_shift_reg_595.sv
// tb/tb_shift_reg_595.sv - directed self-checking bench for shift_reg_595
module tb_shift_reg_595;

`ifdef SHIFT595_INPUT_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    logic [7:0] exp_sr;

    shift_reg_595_if bus ();

    shift_reg_595 #(.RST_Q(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] qout();
        return {bus.pin7, bus.pin6, bus.pin5, bus.pin4, bus.pin3, bus.pin2, bus.pin1, bus.pin15};
    endfunction

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_sr(input logic b);
        bus.pin14 = b;
        tick(1);
        bus.pin11 = 1'b1;
        exp_sr = {exp_sr[6:0], b};
        tick(LAT);
        chk8("qh_prime_track", {7'd0, bus.pin9}, {7'd0, exp_sr[7]});
        bus.pin11 = 1'b0;
        tick(LAT);
    endtask

    task automatic pulse_rclk();
        bus.pin12 = 1'b1;
        tick(LAT);
        bus.pin12 = 1'b0;
        tick(LAT);
    endtask

    task automatic pulse_tied();
        bus.pin11 = 1'b1;
        bus.pin12 = 1'b1;
        tick(LAT);
        bus.pin11 = 1'b0;
        bus.pin12 = 1'b0;
        tick(LAT);
    endtask

    initial begin
        logic [7:0] pat;
        n_cmp = 0;
        n_bad = 0;
        exp_sr = 8'h00;
        pat = 8'hA5;
        bus.pin14 = 1'b0;
        bus.pin11 = 1'b0;
        bus.pin12 = 1'b0;
        bus.pin10 = 1'b1;
        bus.pin13 = 1'b0;
        bus.pin8  = 1'b0;
        bus.pin16 = 1'b1;
        rst = 1'b1;

        // reset state and output-enable tri-state
        tick(1);
        chk8("reset_q", qout(), 8'h00);
        chk8("reset_qh_prime", {7'd0, bus.pin9}, 8'h00);
        rst = 1'b0;
        bus.pin13 = 1'b1;
        #1;
        n_cmp++; assert (bus.pin15 === 1'bz) else begin n_bad++; $error("FAIL oe_z_pin15 observed=%b expected=z", bus.pin15); end
        n_cmp++; assert (bus.pin1 === 1'bz) else begin n_bad++; $error("FAIL oe_z_pin1 observed=%b expected=z", bus.pin1); end
        n_cmp++; assert (bus.pin2 === 1'bz) else begin n_bad++; $error("FAIL oe_z_pin2 observed=%b expected=z", bus.pin2); end
        n_cmp++; assert (bus.pin3 === 1'bz) else begin n_bad++; $error("FAIL oe_z_pin3 observed=%b expected=z", bus.pin3); end
        n_cmp++; assert (bus.pin4 === 1'bz) else begin n_bad++; $error("FAIL oe_z_pin4 observed=%b expected=z", bus.pin4); end
        n_cmp++; assert (bus.pin5 === 1'bz) else begin n_bad++; $error("FAIL oe_z_pin5 observed=%b expected=z", bus.pin5); end
        n_cmp++; assert (bus.pin6 === 1'bz) else begin n_bad++; $error("FAIL oe_z_pin6 observed=%b expected=z", bus.pin6); end
        n_cmp++; assert (bus.pin7 === 1'bz) else begin n_bad++; $error("FAIL oe_z_pin7 observed=%b expected=z", bus.pin7); end
        bus.pin13 = 1'b0;
        tick(1);

        // serial load of A5, MSB first, then latch with exact latency check
        for (int i = 7; i >= 0; i--) pulse_sr(pat[i]);
        bus.pin12 = 1'b1;
        tick(LAT - 1);
        chk8("a5_before_latency", qout(), 8'h00);
        tick(1);
        chk8("a5_at_latency", qout(), 8'hA5);
        bus.pin12 = 1'b0;
        tick(LAT);

        // tied clocks with SER=1 from a cleared shift register
        bus.pin14 = 1'b1;
        bus.pin10 = 1'b0;
        tick(LAT + 1);
        bus.pin10 = 1'b1;
        tick(LAT);
        chk8("clear_qh_prime", {7'd0, bus.pin9}, 8'h00);
        for (int i = 0; i < 8; i++) pulse_tied();
        chk8("tied_storage", qout(), 8'h7F);
        chk8("tied_qh_prime", {7'd0, bus.pin9}, 8'h01);

        // clear has priority over a simultaneous shift edge and leaves storage alone
        pulse_rclk();
        chk8("latch_ff", qout(), 8'hFF);
        bus.pin10 = 1'b0;
        tick(1);
        bus.pin11 = 1'b1;
        tick(LAT);
        chk8("clr_prio_qh_prime", {7'd0, bus.pin9}, 8'h00);
        chk8("clr_keeps_storage", qout(), 8'hFF);
        bus.pin11 = 1'b0;
        bus.pin10 = 1'b1;
        tick(LAT);
        pulse_rclk();
        chk8("clr_sr_zero", qout(), 8'h00);

        // reset mid-shift with SRCLK held high across release
        exp_sr = 8'h00;
        for (int i = 0; i < 3; i++) pulse_sr(1'b1);
        pulse_rclk();
        chk8("three_bits_latched", qout(), 8'h07);
        bus.pin11 = 1'b1;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk8("mid_reset_q", qout(), 8'h00);
        tick(LAT + 2);
        chk8("mid_reset_qh_prime", {7'd0, bus.pin9}, 8'h00);
        bus.pin11 = 1'b0;
        tick(LAT);
        pulse_rclk();
        chk8("no_spurious_shift", qout(), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
